// File: rtl/channel_cfg_sequencer_pkg.sv
// Shared types and constants for the channel configuration sequencer:
// FSM encoding, channel command codes, error codes and clock-value width.
package channel_cfg_sequencer_pkg;

    localparam int unsigned CLK_W = 25;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOCK_WAIT = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_RESET = 3'd1;
    localparam logic [2:0] CMD_RUN   = 3'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_WIDTH   = 2'd1;
    localparam logic [1:0] ERR_ORDER   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Datawidth codes 1..4 are the only ones the channel understands.
    function automatic logic width_legal(input logic [2:0] width);
        return (width != 3'd0) && (width <= 3'd4);
    endfunction

endpackage

// File: rtl/channel_cfg_sequencer_edge_sync.sv
// Two-flop synchronizer for the asynchronous channel clock plus a rising-edge
// detector; rise is high for one system-clock cycle per synchronized edge.
module edge_sync (
    input  logic clock,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain and history flop for edge detection.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/channel_cfg_sequencer.sv
// Sequences a channel through reset, run and clock-lock on each accepted
// configuration request, reporting completion or the reason for failure.
module channel_cfg_sequencer
    import channel_cfg_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned LOCK_EDGES  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_width,
    input  logic [CLK_W-1:0] req_wanted,
    input  logic [CLK_W-1:0] req_earlier,
    output logic [2:0]       ctrl_sig,
    output logic [2:0]       val,
    output logic [CLK_W-1:0] wanted_cl_val,
    output logic [CLK_W-1:0] earlier_cl_val,
    input  logic             ref_clock,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  EDGE_LAST   = 4'(LOCK_EDGES - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [1:0]         chk_code_s;
    logic               rise_s;
    logic [15:0]        cyc_cnt_r;
    logic [3:0]         edge_cnt_r;
    logic [2:0]         cap_width_r;
    logic [CLK_W-1:0]   cap_wanted_r;
    logic [CLK_W-1:0]   cap_earlier_r;
    logic               req_ready_r;
    logic [2:0]         ctrl_sig_r;
    logic [2:0]         val_r;
    logic [CLK_W-1:0]   wanted_cl_val_r;
    logic [CLK_W-1:0]   earlier_cl_val_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [1:0]         err_code_r;

    edge_sync u_edge_sync (
        .clock    (clock),
        .rst_n    (rst_n),
        .async_in (ref_clock),
        .rise     (rise_s)
    );

    // Next-state decode; lock success is checked before timeout so it wins a tie.
    always_comb begin
        next_state_s = state_r;
        chk_code_s   = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) next_state_s = ST_CHECK;
                else           next_state_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (!width_legal(cap_width_r)) begin
                    next_state_s = ST_ERR;
                    chk_code_s   = ERR_WIDTH;
                end else if (cap_wanted_r > cap_earlier_r) begin
                    next_state_s = ST_ERR;
                    chk_code_s   = ERR_ORDER;
                end else begin
                    next_state_s = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (cyc_cnt_r == SETTLE_LAST) next_state_s = ST_RUN;
                else                          next_state_s = ST_RST_HOLD;
            end
            ST_RUN: begin
                if (cap_wanted_r == cap_earlier_r) next_state_s = ST_DONE;
                else                               next_state_s = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (rise_s && (edge_cnt_r == EDGE_LAST)) next_state_s = ST_DONE;
                else if (cyc_cnt_r == TMO_LAST)          next_state_s = ST_ERR;
                else                                     next_state_s = ST_LOCK_WAIT;
            end
            ST_DONE:  next_state_s = ST_IDLE;
            ST_ERR:   next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // State register and per-state cycle/edge counters, cleared on every state change.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cyc_cnt_r  <= 16'd0;
            edge_cnt_r <= 4'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                cyc_cnt_r  <= 16'd0;
                edge_cnt_r <= 4'd0;
            end else begin
                cyc_cnt_r <= cyc_cnt_r + 16'd1;
                if (rise_s) edge_cnt_r <= edge_cnt_r + 4'd1;
            end
        end
    end

    // Request capture on handshake; data arriving while busy is never sampled.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cap_width_r   <= 3'd0;
            cap_wanted_r  <= '0;
            cap_earlier_r <= '0;
        end else if (state_r == ST_IDLE && req_valid) begin
            cap_width_r   <= req_width;
            cap_wanted_r  <= req_wanted;
            cap_earlier_r <= req_earlier;
        end
    end

    // Registered outputs, computed from the upcoming state so they align with it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r      <= 1'b1;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            err_r            <= 1'b0;
            err_code_r       <= ERR_NONE;
            ctrl_sig_r       <= CMD_IDLE;
            val_r            <= 3'd0;
            wanted_cl_val_r  <= '0;
            earlier_cl_val_r <= '0;
        end else begin
            req_ready_r <= (next_state_s == ST_IDLE);
            busy_r      <= (next_state_s != ST_IDLE);
            done_r      <= (next_state_s == ST_DONE);
            err_r       <= (next_state_s == ST_ERR);

            if (state_r == ST_IDLE && req_valid) begin
                err_code_r <= ERR_NONE;
            end else if (state_r == ST_CHECK && next_state_s == ST_ERR) begin
                err_code_r <= chk_code_s;
            end else if (state_r == ST_LOCK_WAIT && next_state_s == ST_ERR) begin
                err_code_r <= ERR_TIMEOUT;
            end

            // A lock timeout parks the channel in reset until a later success.
            if (state_r == ST_CHECK && next_state_s == ST_RST_HOLD) begin
                ctrl_sig_r       <= CMD_RESET;
                val_r            <= cap_width_r;
                wanted_cl_val_r  <= cap_wanted_r;
                earlier_cl_val_r <= cap_earlier_r;
            end else if (state_r == ST_RST_HOLD && next_state_s == ST_RUN) begin
                ctrl_sig_r <= CMD_RUN;
            end else if (state_r == ST_LOCK_WAIT && next_state_s == ST_ERR) begin
                ctrl_sig_r <= CMD_RESET;
            end
        end
    end

    assign req_ready      = req_ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign err_code       = err_code_r;
    assign ctrl_sig       = ctrl_sig_r;
    assign val            = val_r;
    assign wanted_cl_val  = wanted_cl_val_r;
    assign earlier_cl_val = earlier_cl_val_r;

endmodule

// File: tb/tb_channel_cfg_sequencer.sv
// Directed and randomized bench for channel_cfg_sequencer; expected behaviour
// comes from a request-level model of the sequence and its timing.
module tb_channel_cfg_sequencer;

    localparam int S = 16;
    localparam int L = 4;
    localparam int T = 64;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_width = 3'd0;
    logic [24:0] req_wanted = 25'd0;
    logic [24:0] req_earlier = 25'd0;
    logic [2:0]  ctrl_sig;
    logic [2:0]  val;
    logic [24:0] wanted_cl_val;
    logic [24:0] earlier_cl_val;
    logic        ref_clock = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;

    // Model of the channel-facing state left behind by earlier requests.
    logic [2:0]  m_ctrl;
    logic [2:0]  m_val;
    logic [24:0] m_wanted;
    logic [24:0] m_earlier;
    logic [1:0]  m_code;

    channel_cfg_sequencer #(
        .SETTLE_CYC  (S),
        .LOCK_EDGES  (L),
        .TIMEOUT_CYC (T)
    ) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_width      (req_width),
        .req_wanted     (req_wanted),
        .req_earlier    (req_earlier),
        .ctrl_sig       (ctrl_sig),
        .val            (val),
        .wanted_cl_val  (wanted_cl_val),
        .earlier_cl_val (earlier_cl_val),
        .ref_clock      (ref_clock),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Channel clock level driven n cycles after the handshake edge.
    function automatic bit refv(input int n, input int period, input int phase);
        if (period == 0) return 1'b0;
        return bit'(((n + phase) / period) % 2);
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctrl"}, ctrl_sig, 0);
        chk({tag, "_val"}, val, 0);
        chk({tag, "_wanted"}, wanted_cl_val, 0);
        chk({tag, "_earlier"}, earlier_cl_val, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_code"}, err_code, 0);
    endtask

    // One full request: handshake, per-cycle checks, then final-state checks.
    // outcome: 0 done, 1 bad width, 2 wanted>earlier, 3 lock timeout.
    task automatic run_cfg(input logic [2:0] w, input logic [24:0] wa, input logic [24:0] ea,
                           input int period, input int phase);
        int outcome;
        int endc;
        int cnt;
        logic [2:0] exp_ctrl;
        outcome = 0;
        endc = S + 2;
        if (w == 3'd0 || w > 3'd4) begin
            outcome = 1;
            endc = 1;
        end else if (wa > ea) begin
            outcome = 2;
            endc = 1;
        end else if (wa != ea) begin
            // A channel-clock rise driven at cycle j is counted at edge j+3.
            cnt = 0;
            outcome = 3;
            endc = S + 2 + T;
            for (int k = S + 3; k <= S + 2 + T; k++) begin
                if (refv(k - 3, period, phase) && !refv(k - 4, period, phase)) begin
                    cnt++;
                    if (cnt == L) begin
                        outcome = 0;
                        endc = k;
                        break;
                    end
                end
            end
        end

        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_width = w;
        req_wanted = wa;
        req_earlier = ea;
        step();
        for (int n = 0; n <= endc + 1; n++) begin
            if (outcome == 1 || outcome == 2 || n == 0) exp_ctrl = m_ctrl;
            else if (n <= S) exp_ctrl = 3'd1;
            else if (n < endc) exp_ctrl = 3'd2;
            else exp_ctrl = (outcome == 0) ? 3'd2 : 3'd1;
            chk("ctrl_sig", ctrl_sig, exp_ctrl);
            chk("busy", busy, (n <= endc) ? 1 : 0);
            chk("req_ready", req_ready, (n <= endc) ? 0 : 1);
            chk("done", done, (n == endc && outcome == 0) ? 1 : 0);
            chk("err", err, (n == endc && outcome != 0) ? 1 : 0);
            chk("err_code", err_code, (n < endc) ? 0 : outcome);
            ref_clock = refv(n, period, phase);
            if (n < endc) begin
                req_valid = 1'($urandom_range(0, 1));
                req_width = 3'($urandom);
                req_wanted = 25'($urandom);
                req_earlier = 25'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (n <= endc) step();
        end

        if (outcome == 0 || outcome == 3) begin
            m_ctrl = (outcome == 0) ? 3'd2 : 3'd1;
            m_val = w;
            m_wanted = wa;
            m_earlier = ea;
        end
        m_code = 2'(outcome);
        chk("final_ctrl", ctrl_sig, m_ctrl);
        chk("final_val", val, m_val);
        chk("final_wanted", wanted_cl_val, m_wanted);
        chk("final_earlier", earlier_cl_val, m_earlier);
        chk("final_code", err_code, m_code);
    endtask

    initial begin
        logic [24:0] a;
        logic [24:0] b;
        int mode;
        m_ctrl = 3'd0;
        m_val = 3'd0;
        m_wanted = 25'd0;
        m_earlier = 25'd0;
        m_code = 2'd0;

        // Reset state, then ready in the first cycle after release.
        #12;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", req_ready, 1);
        step();

        // Nominal lock with channel clock toggling every 3 cycles.
        run_cfg(3'd3, 25'd5, 25'd20, 3, 0);
        // Illegal widths, then wanted above earlier.
        run_cfg(3'd0, 25'd5, 25'd20, 3, 0);
        run_cfg(3'd5, 25'd1, 25'd2, 2, 1);
        run_cfg(3'd2, 25'd30, 25'd20, 3, 0);
        // Bypass: equal clock values skip the lock wait.
        run_cfg(3'd1, 25'd20, 25'd20, 0, 0);
        // Static channel clock times out, then a good request recovers.
        run_cfg(3'd4, 25'd7, 25'd100, 0, 0);
        run_cfg(3'd0, 25'd7, 25'd100, 0, 0);
        run_cfg(3'd3, 25'd9, 25'd50, 2, 1);
        // Boundary: width 4 with wanted one below earlier.
        run_cfg(3'd4, 25'h1FFFFFE, 25'h1FFFFFF, 1, 0);

        // Randomized requests; slow channel clocks exercise the timeout path.
        for (int i = 0; i < 14; i++) begin
            mode = $urandom_range(0, 3);
            a = 25'($urandom);
            b = 25'($urandom);
            if (mode == 0) b = a;
            else if (mode == 1 && a < b) begin a = a ^ b; b = a ^ b; a = a ^ b; end
            else if (mode >= 2 && a > b) begin a = a ^ b; b = a ^ b; a = a ^ b; end
            run_cfg(3'($urandom), a, b, $urandom_range(0, 12), $urandom_range(0, 23));
        end

        // Reset during the channel-reset hold abandons the sequence.
        chk("ready_before_abort", req_ready, 1);
        req_valid = 1'b1;
        req_width = 3'd2;
        req_wanted = 25'd3;
        req_earlier = 25'd9;
        ref_clock = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        chk("abort_in_hold", ctrl_sig, 1);
        rst_n = 1'b0;
        #2;
        check_zero_outputs("abort");
        chk("abort_ready", req_ready, 1);
        #2;
        rst_n = 1'b1;
        m_ctrl = 3'd0;
        m_val = 3'd0;
        m_wanted = 25'd0;
        m_earlier = 25'd0;
        m_code = 2'd0;
        run_cfg(3'd1, 25'd4, 25'd8, 3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
